// File: rtl/dds_multi_ctrl_if.sv
// Byte-level link between the SPI slave front end and the DDS controller.
// The SPI side drives received bytes and frame state; the controller returns the next tx byte.
interface dds_multi_ctrl_if;
  logic       frame_active;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;

  modport master (
    output frame_active,
    output rx_byte,
    output rx_valid,
    input  tx_byte
  );

  modport slave (
    input  frame_active,
    input  rx_byte,
    input  rx_valid,
    output tx_byte
  );
endinterface

// File: rtl/dds_multi_ctrl.sv
// Multi-channel DDS controller: SPI command parser, shadow/active frequency words,
// and one phase accumulator per channel feeding a sine-ROM address.
module dds_multi_ctrl #(
  parameter int              NUM_CH        = 2,
  parameter int              FW_W          = 32,
  parameter int              ACC_W         = 32,
  parameter int              ADDR_W        = 12,
  parameter logic [FW_W-1:0] DEFAULT_FWORD = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  dds_multi_ctrl_if.slave          bus,
  output logic [NUM_CH*ADDR_W-1:0] addr_out,
  output logic [NUM_CH-1:0]        wrap_strobe,
  output logic                     err
);

  localparam int FW_BYTES = FW_W / 8;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W    = (FW_BYTES > 1) ? $clog2(FW_BYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_DROP
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [FW_W-1:0]  r_shadow [NUM_CH];
  logic [FW_W-1:0]  r_active [NUM_CH];
  logic [ACC_W-1:0] r_acc    [NUM_CH];
  logic [ACC_W:0]   w_sum    [NUM_CH];
  logic [NUM_CH-1:0] r_wrap;

  logic [CH_W-1:0]  r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [FW_W-1:0]  r_wbuf;
  logic [FW_W-1:0]  r_rbuf;
  logic [7:0]       r_tx;
  logic             r_err;

  logic [1:0]       w_op;
  logic [3:0]       w_ch;
  logic [CH_W-1:0]  w_chi;
  logic             w_prs;
  logic             w_ch_ok;
  logic             w_is_wr;
  logic             w_is_apl;
  logic             w_is_rd;
  logic             w_bad;
  logic             w_last;
  logic [FW_W-1:0]  w_wshift;

  logic w_cmd_wr;
  logic w_cmd_rd;
  logic w_cmd_apl;
  logic w_cmd_err;
  logic w_wr_byte;
  logic w_rd_byte;

  assign w_op     = bus.rx_byte[7:6];
  assign w_prs    = bus.rx_byte[5];
  assign w_ch     = bus.rx_byte[3:0];
  assign w_chi    = CH_W'(w_ch);
  assign w_ch_ok  = ({1'b0, w_ch} < 5'(NUM_CH));
  assign w_is_wr  = (w_op == 2'b00);
  assign w_is_apl = (w_op == 2'b01);
  assign w_is_rd  = (w_op == 2'b10);
  assign w_bad    = (w_op == 2'b11)
                  | ((w_is_wr | w_is_rd) & ~w_ch_ok);
  assign w_last   = (r_cnt == CNT_W'(FW_BYTES - 1));
  assign w_wshift = (r_wbuf << 8) | FW_W'(bus.rx_byte);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Frame end dominates: a byte arriving with frame_active low is dropped.
  always_comb begin
    w_nxt     = r_state;
    w_cmd_wr  = 1'b0;
    w_cmd_rd  = 1'b0;
    w_cmd_apl = 1'b0;
    w_cmd_err = 1'b0;
    w_wr_byte = 1'b0;
    w_rd_byte = 1'b0;
    if (!bus.frame_active) begin
      w_nxt = S_IDLE;
    end else if (bus.rx_valid) begin
      unique case (r_state)
        S_IDLE: begin
          unique case (1'b1)
            w_bad: begin
              w_cmd_err = 1'b1;
              w_nxt     = S_DROP;
            end
            w_is_apl: begin
              w_cmd_apl = 1'b1;
              w_nxt     = S_DROP;
            end
            (w_is_wr & w_ch_ok): begin
              w_cmd_wr = 1'b1;
              w_nxt    = S_WR;
            end
            (w_is_rd & w_ch_ok): begin
              w_cmd_rd = 1'b1;
              w_nxt    = S_RD;
            end
            default: ;
          endcase
        end
        S_WR: begin
          w_wr_byte = 1'b1;
          if (w_last) w_nxt = S_DROP;
        end
        S_RD: begin
          w_rd_byte = 1'b1;
          if (w_last) w_nxt = S_DROP;
        end
        S_DROP: ;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      w_sum[n] = {1'b0, r_acc[n]} + (ACC_W + 1)'(r_active[n]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        r_shadow[n] <= DEFAULT_FWORD;
        r_active[n] <= DEFAULT_FWORD;
        r_acc[n]    <= '0;
      end
      r_wrap <= '0;
      r_ch   <= '0;
      r_cnt  <= '0;
      r_wbuf <= '0;
      r_rbuf <= '0;
      r_tx   <= 8'h00;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_cmd_err;

      if (w_cmd_wr) begin
        r_ch  <= w_chi;
        r_cnt <= '0;
      end

      // Shadow only changes once the final byte lands; aborts leave it intact.
      if (w_wr_byte) begin
        r_wbuf <= w_wshift;
        r_cnt  <= r_cnt + 1'b1;
        if (w_last) r_shadow[r_ch] <= w_wshift;
      end

      if (w_cmd_rd) begin
        r_tx   <= r_active[w_chi][FW_W-1 -: 8];
        r_rbuf <= r_active[w_chi] << 8;
        r_cnt  <= '0;
      end

      if (w_rd_byte) begin
        r_tx   <= w_last ? 8'hA5 : r_rbuf[FW_W-1 -: 8];
        r_rbuf <= r_rbuf << 8;
        r_cnt  <= r_cnt + 1'b1;
      end

      if (w_cmd_apl) begin
        for (int n = 0; n < NUM_CH; n++) begin
          r_active[n] <= r_shadow[n];
        end
      end

      for (int n = 0; n < NUM_CH; n++) begin
        if (w_cmd_apl && w_prs) begin
          r_acc[n]  <= '0;
          r_wrap[n] <= 1'b0;
        end else begin
          r_acc[n]  <= w_sum[n][ACC_W-1:0];
          r_wrap[n] <= w_sum[n][ACC_W];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_addr
    assign addr_out[g*ADDR_W +: ADDR_W] = r_acc[g][ACC_W-1 -: ADDR_W];
  end

  assign wrap_strobe = r_wrap;
  assign err         = r_err;
  assign bus.tx_byte = r_tx;

endmodule

// File: tb/tb_dds_multi_ctrl.sv
// Bench for dds_multi_ctrl: frame-level command model compared every cycle,
// plus literal expectations for the key command sequences.
module tb_dds_multi_ctrl;

  localparam int NCH = 2;
  localparam int AW  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dds_multi_ctrl_if bus ();

  logic [NCH*AW-1:0] addr_out;
  logic [NCH-1:0]    wrap_strobe;
  logic              err;

  int total = 0;
  int bad   = 0;

  dds_multi_ctrl #(
    .NUM_CH       (NCH),
    .FW_W         (32),
    .ACC_W        (32),
    .ADDR_W       (AW),
    .DEFAULT_FWORD(32'd0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .addr_out   (addr_out),
    .wrap_strobe(wrap_strobe),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] m_shadow [NCH];
  logic [31:0] m_active [NCH];
  logic [31:0] m_acc    [NCH];
  logic        m_wrap   [NCH];
  logic [31:0] m_buf;
  logic [31:0] m_rdw;
  logic [7:0]  m_cmd;
  logic [7:0]  m_tx;
  logic        m_err;
  logic        m_bad;
  int          m_pos;

  // Model: m_pos is the byte position within the current frame.
  always @(posedge clk or negedge rst) begin : model
    logic [32:0] s;
    logic [31:0] nb;
    logic [7:0]  b;
    logic        apply;
    logic        clr;
    int          ch;
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] <= 32'd0;
        m_active[i] <= 32'd0;
        m_acc[i]    <= 32'd0;
        m_wrap[i]   <= 1'b0;
      end
      m_buf <= 32'd0;
      m_rdw <= 32'd0;
      m_cmd <= 8'd0;
      m_tx  <= 8'd0;
      m_err <= 1'b0;
      m_bad <= 1'b1;
      m_pos <= 0;
    end else begin
      apply = 1'b0;
      clr   = 1'b0;
      b     = bus.rx_byte;
      m_err <= 1'b0;
      if (!bus.frame_active) begin
        m_pos <= 0;
      end else if (bus.rx_valid) begin
        m_pos <= m_pos + 1;
        if (m_pos == 0) begin
          ch = int'(b[3:0]);
          m_cmd <= b;
          if (b[7:6] == 2'b11 || (b[7:6] != 2'b01 && ch >= NCH)) begin
            m_err <= 1'b1;
            m_bad <= 1'b1;
          end else begin
            m_bad <= 1'b0;
            if (b[7:6] == 2'b01) begin
              apply = 1'b1;
              clr   = b[5];
            end
            if (b[7:6] == 2'b10) begin
              m_tx  <= m_active[ch][31:24];
              m_rdw <= m_active[ch];
            end
          end
        end else if (!m_bad && m_pos <= 4) begin
          ch = int'(m_cmd[3:0]);
          if (m_cmd[7:6] == 2'b00) begin
            nb = {m_buf[23:0], b};
            m_buf <= nb;
            if (m_pos == 4) m_shadow[ch] <= nb;
          end
          if (m_cmd[7:6] == 2'b10) begin
            m_tx <= (m_pos == 4) ? 8'hA5 : 8'(m_rdw >> (8 * (3 - m_pos)));
          end
        end
      end
      for (int n = 0; n < NCH; n++) begin
        if (clr) begin
          m_acc[n]  <= 32'd0;
          m_wrap[n] <= 1'b0;
        end else begin
          s = {1'b0, m_acc[n]} + {1'b0, m_active[n]};
          m_acc[n]  <= s[31:0];
          m_wrap[n] <= s[32];
        end
        if (apply) m_active[n] <= m_shadow[n];
      end
    end
  end

  always @(negedge clk) begin
    for (int n = 0; n < NCH; n++) begin
      check($sformatf("addr%0d", n), 32'(addr_out[n*AW +: AW]),
            32'(m_acc[n][31:20]));
      check($sformatf("wrap%0d", n), 32'(wrap_strobe[n]), 32'(m_wrap[n]));
    end
    check("err", 32'(err), 32'(m_err));
    check("tx", 32'(bus.tx_byte), 32'(m_tx));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sb(input logic [7:0] b);
    tick();
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic fs();
    tick();
    bus.frame_active = 1'b1;
  endtask

  task automatic fe();
    tick();
    bus.frame_active = 1'b0;
    tick();
  endtask

  logic [7:0] exp_rd [6];

  initial begin
    bus.frame_active = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_byte      = 8'h00;
    #1 rst = 1'b0;
    #2;
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_tx", 32'(bus.tx_byte), 32'h00);
    check("rst_err", 32'(err), 32'd0);
    #19 rst = 1'b1;
    repeat (3) tick();

    // ch0 = 0x80000000, then apply with phase reset
    fs(); sb(8'h00); sb(8'h80); sb(8'h00); sb(8'h00); sb(8'h00); fe();
    fs(); sb(8'h60);
    check("t2_addr0_a", 32'(addr_out[AW-1:0]), 32'h000);
    check("t2_wrap0_a", 32'(wrap_strobe[0]), 32'd0);
    tick();
    check("t2_addr0_b", 32'(addr_out[AW-1:0]), 32'h800);
    check("t2_wrap0_b", 32'(wrap_strobe[0]), 32'd0);
    tick();
    check("t2_addr0_c", 32'(addr_out[AW-1:0]), 32'h000);
    check("t2_wrap0_c", 32'(wrap_strobe[0]), 32'd1);
    check("t2_addr1", 32'(addr_out[2*AW-1:AW]), 32'h000);
    check("t2_wrap1", 32'(wrap_strobe[1]), 32'd0);
    fe();
    repeat (4) tick();

    // aborted write to ch1, then apply: ch1 must still read back zero
    fs(); sb(8'h01); sb(8'h12); sb(8'h34); sb(8'h56); fe();
    fs(); sb(8'h40); fe();
    fs(); sb(8'h81);
    check("t3_rd0", 32'(bus.tx_byte), 32'h00);
    for (int i = 1; i < 4; i++) begin
      sb(8'h00);
      check($sformatf("t3_rd%0d", i), 32'(bus.tx_byte), 32'h00);
    end
    sb(8'h00);
    check("t3_end", 32'(bus.tx_byte), 32'hA5);
    fe();

    // full write of 0x12345678 to ch1, apply, read back
    fs(); sb(8'h01); sb(8'h12); sb(8'h34); sb(8'h56); sb(8'h78); fe();
    fs(); sb(8'h40); fe();
    exp_rd = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hA5, 8'hA5};
    fs(); sb(8'h81);
    check("t5_rd0", 32'(bus.tx_byte), 32'(exp_rd[0]));
    for (int i = 1; i < 6; i++) begin
      sb(8'h00);
      check($sformatf("t5_rd%0d", i), 32'(bus.tx_byte), 32'(exp_rd[i]));
    end
    fe();

    // bad channel and reserved op
    fs(); sb(8'h05);
    check("t4_err_ch", 32'(err), 32'd1);
    tick();
    check("t4_err_ch_off", 32'(err), 32'd0);
    sb(8'h00); sb(8'h01);
    check("t4_err_quiet", 32'(err), 32'd0);
    fe();
    fs(); sb(8'hC0);
    check("t4_err_rsv", 32'(err), 32'd1);
    tick();
    check("t4_err_rsv_off", 32'(err), 32'd0);
    sb(8'h60);
    fe();
    repeat (3) tick();

    // last write byte coincides with frame end: dropped
    fs(); sb(8'h01); sb(8'hAA); sb(8'hBB); sb(8'hCC);
    tick();
    bus.frame_active = 1'b0;
    bus.rx_byte      = 8'hDD;
    bus.rx_valid     = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
    tick();

    // byte outside a frame is ignored
    sb(8'h60);
    repeat (2) tick();

    // write without apply, then apply without phase reset
    fs(); sb(8'h00); sb(8'h40); sb(8'h00); sb(8'h00); sb(8'h00); fe();
    repeat (6) tick();
    fs(); sb(8'h40); fe();
    repeat (8) tick();
    fs(); sb(8'h80);
    check("t6_rd0", 32'(bus.tx_byte), 32'h40);
    fe();
    fs(); sb(8'h81);
    check("t6_rd1", 32'(bus.tx_byte), 32'h12);
    fe();

    // mid-run reset
    #1 rst = 1'b0;
    #1;
    check("t1_addr", 32'(addr_out), 32'd0);
    check("t1_tx", 32'(bus.tx_byte), 32'h00);
    check("t1_err", 32'(err), 32'd0);
    #10 rst = 1'b1;
    repeat (4) tick();
    fs(); sb(8'h81);
    check("t1_rd_default", 32'(bus.tx_byte), 32'h00);
    fe();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
